// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch unit paired with the control decoder. Owns the program
// counter, drives the asynchronous instruction ROM address, and hands the
// fetched machine code to the decoder together with a Valid qualifier. Next-PC
// selection uses the decoder's Branch/Jump outputs, the ALU Taken flag and a
// small branch-target LUT that is loaded while the core is not running.
//
// Control FSM: IDLE -> (Start) -> RUN -> (HALT_CODE fetched) -> HALT -> (Start) -> RUN
//
// Ports:
//   Clk         system clock, all state changes on the rising edge
//   Reset       synchronous, active-high; wins over every other input
//   Start       begin execution from PC 0 (IDLE or HALT only)
//   Stall       hold PC and suppress Valid for this cycle
//   Branch      conditional branch request from the decoder
//   Jump        unconditional jump request from the decoder (beats Branch)
//   Taken       ALU condition flag qualifying Branch
//   TargetIdx   LUT index holding the branch/jump target
//   LutWe       LUT write strobe, honoured in IDLE and HALT
//   LutAddr     LUT write index
//   LutData     LUT write data (a PC value)
//   MachCode    ROM read data for address ProgCtr, same cycle
//   ProgCtr     current PC / ROM address
//   Instr       instruction to the decoder (0 outside RUN)
//   Valid       Instr is live; downstream gates RegWrite/MemWrite with it
//   Done        program has halted
//   CycleCount  number of clocks spent in RUN (saturating)
//
// Build option:
//   INSTR_FETCH_CYCLE_CNT_EN  when defined, CycleCount counts RUN clocks
//                             (stalls included); when undefined the counter is
//                             not built and CycleCount reads 0.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int            PCW       = 10,
  parameter int            IW        = 9,
  parameter int            LUTW      = 5,
  parameter logic [IW-1:0] HALT_CODE = 9'h1FF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            Taken,
  input  logic [LUTW-1:0] TargetIdx,
  input  logic            LutWe,
  input  logic [LUTW-1:0] LutAddr,
  input  logic [PCW-1:0]  LutData,
  input  logic [IW-1:0]   MachCode,
  output logic [PCW-1:0]  ProgCtr,
  output logic [IW-1:0]   Instr,
  output logic            Valid,
  output logic            Done,
  output logic [31:0]     CycleCount
);

  localparam int LUT_DEPTH = 1 << LUTW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state;
  logic [PCW-1:0]  pc;
  logic            done;
  logic [PCW-1:0]  lut [LUT_DEPTH];

  logic            in_run;
  logic            is_halt;
  logic            live;
  logic            redirect;
  logic [PCW-1:0]  target;
  logic [PCW-1:0]  pc_inc;

  // Saturating increment for the RUN-cycle counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF)
      sat_inc = val;
    else
      sat_inc = val + 32'd1;
  endfunction

  // Fetch qualification: the ROM is combinational, so the instruction for
  // the current PC is already on MachCode and can be redirected this cycle.
  assign in_run   = (state == S_RUN);
  assign is_halt  = (MachCode == HALT_CODE);
  assign live     = in_run & ~Stall & ~is_halt;
  // Jump and taken-branch share the same target path; decoder strobes are
  // only meaningful while the instruction that produced them is live.
  assign redirect = live & (Jump | (Branch & Taken));
  assign target   = lut[TargetIdx];
  assign pc_inc   = pc + PCW'(1);

  assign ProgCtr  = pc;
  assign Instr    = in_run ? MachCode : '0;
  assign Valid    = live;
  assign Done     = done;

  // Control FSM and program counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state <= S_RUN;
            pc    <= '0;
          end
        end
        S_RUN: begin
          // A stall freezes everything, including recognition of HALT_CODE.
          if (!Stall) begin
            if (is_halt) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else if (redirect) begin
              pc <= target;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        S_HALT: begin
          if (Start) begin
            state <= S_RUN;
            pc    <= '0;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          pc    <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Branch-target LUT: writable only while the core is not fetching, so a
  // running program always sees a stable target table.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++)
        lut[i] <= '0;
    end else if (LutWe && (state != S_RUN)) begin
      lut[LutAddr] <= LutData;
    end
  end

`ifdef INSTR_FETCH_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  // Counts every RUN clock including stalls; a fresh Start restarts it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycle_cnt <= '0;
    end else if ((state != S_RUN) && Start) begin
      cycle_cnt <= '0;
    end else if (state == S_RUN) begin
      cycle_cnt <= sat_inc(cycle_cnt);
    end
  end

  assign CycleCount = cycle_cnt;
`else
  assign CycleCount = 32'd0;
`endif

endmodule
